// File: rtl/mgpio_pkg.sv
// mgpio arbiter package: shared FSM state type and bus data width.
package mgpio_pkg;

    localparam int MGPIO_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } arb_state_e;

    // Even parity of one bus byte, used when protecting latched data.
    function automatic logic byte_parity(input logic [MGPIO_DATA_W-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/mgpio_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// found when searching upward from ptr, wrapping at N-1.
module mgpio_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_vec,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);

    logic [IDX_W:0] sum_s;
    logic [IDX_W:0] cand_s;

    // Scan offsets from the highest down so the smallest offset from ptr wins.
    always_comb begin
        valid  = 1'b0;
        idx    = {IDX_W{1'b0}};
        sum_s  = {(IDX_W+1){1'b0}};
        cand_s = {(IDX_W+1){1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            sum_s = {1'b0, ptr} + i[IDX_W:0];
            if (sum_s >= N_EXT) begin
                cand_s = sum_s - N_EXT;
            end else begin
                cand_s = sum_s;
            end
            if (req_vec[cand_s[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand_s[IDX_W-1:0];
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/mgpio_arbiter.sv
// Round-robin arbiter sharing one mgpio register bus between REQUESTERS
// masters. Each grant runs IDLE -> ACCESS (one bus cycle) -> ACK.
// Optional feature macro: MGPIO_ARB_LOCK_EN enables a hold-grant lock so a
// master can perform an atomic read-modify-write sequence.
module mgpio_arbiter
    import mgpio_pkg::*;
#(
    parameter int REQUESTERS = 2,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQUESTERS-1:0]          req,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] req_addr,
    input  logic [REQUESTERS*8-1:0]        req_wdata,
    input  logic [REQUESTERS-1:0]          req_write,
    input  logic [REQUESTERS-1:0]          req_lock,
    output logic [REQUESTERS-1:0]          ack,
    output logic [MGPIO_DATA_W-1:0]        rdata,
    output logic                           err,
    output logic [ADDR_WIDTH-1:0]          bus_addr,
    output logic [MGPIO_DATA_W-1:0]        bus_data_in,
    output logic                           bus_write,
    input  logic [MGPIO_DATA_W-1:0]        bus_data_out,
    input  logic                           bus_err
);

    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(REQUESTERS - 1);
    localparam logic [REQUESTERS-1:0] ACK_BASE = {{(REQUESTERS-1){1'b0}}, 1'b1};

    arb_state_e                state_r;
    arb_state_e                next_state_s;
    logic [IDX_W-1:0]          ptr_r;
    logic [IDX_W-1:0]          grant_idx_r;
    logic [REQUESTERS-1:0]     pick_req_s;
    logic [IDX_W-1:0]          pick_idx_s;
    logic                      pick_valid_s;
    logic                      hold_ptr_s;
    logic [ADDR_WIDTH-1:0]     sel_addr_s;
    logic [MGPIO_DATA_W-1:0]   sel_wdata_s;
    logic                      sel_write_s;

    assign sel_addr_s  = req_addr[pick_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata_s = req_wdata[pick_idx_s*MGPIO_DATA_W +: MGPIO_DATA_W];
    assign sel_write_s = req_write[pick_idx_s];

    mgpio_rr_pick #(
        .N     (REQUESTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_vec (pick_req_s),
        .ptr     (ptr_r),
        .idx     (pick_idx_s),
        .valid   (pick_valid_s)
    );

`ifdef MGPIO_ARB_LOCK_EN
    logic             lock_valid_r;
    logic [IDX_W-1:0] lock_owner_r;

    // While the owner keeps requesting, only its request is visible to the picker.
    always_comb begin
        pick_req_s = req;
        if (lock_valid_r && req[lock_owner_r]) begin
            pick_req_s               = {REQUESTERS{1'b0}};
            pick_req_s[lock_owner_r] = 1'b1;
        end else begin
            pick_req_s = req;
        end
    end

    assign hold_ptr_s = lock_valid_r;

    // Each grant re-evaluates the lock from the winner's req_lock; an idle owner drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_valid_r <= 1'b0;
            lock_owner_r <= {IDX_W{1'b0}};
        end else if (state_r == IDLE) begin
            if (pick_valid_s) begin
                lock_valid_r <= req_lock[pick_idx_s];
                lock_owner_r <= pick_idx_s;
            end else begin
                lock_valid_r <= 1'b0;
            end
        end else begin
            lock_valid_r <= lock_valid_r;
        end
    end
`else
    logic lock_unused_s;

    assign lock_unused_s = ^req_lock;
    assign pick_req_s    = req;
    assign hold_ptr_s    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: one bus cycle per grant, then a single ack cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS:  next_state_s = ACK;
            ACK:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath: latch the winner onto the bus, capture the response, pulse ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r       <= {IDX_W{1'b0}};
            grant_idx_r <= {IDX_W{1'b0}};
            ack         <= {REQUESTERS{1'b0}};
            rdata       <= {MGPIO_DATA_W{1'b0}};
            err         <= 1'b0;
            bus_addr    <= {ADDR_WIDTH{1'b0}};
            bus_data_in <= {MGPIO_DATA_W{1'b0}};
            bus_write   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack <= {REQUESTERS{1'b0}};
                    if (pick_valid_s) begin
                        grant_idx_r <= pick_idx_s;
                        bus_addr    <= sel_addr_s;
                        bus_data_in <= sel_wdata_s;
                        bus_write   <= sel_write_s;
                    end else begin
                        bus_addr    <= {ADDR_WIDTH{1'b0}};
                        bus_data_in <= {MGPIO_DATA_W{1'b0}};
                        bus_write   <= 1'b0;
                    end
                end
                ACCESS: begin
                    rdata       <= bus_data_out;
                    err         <= bus_err;
                    ack         <= ACK_BASE << grant_idx_r;
                    bus_addr    <= {ADDR_WIDTH{1'b0}};
                    bus_data_in <= {MGPIO_DATA_W{1'b0}};
                    bus_write   <= 1'b0;
                end
                ACK: begin
                    ack <= {REQUESTERS{1'b0}};
                    if (!hold_ptr_s) begin
                        ptr_r <= (grant_idx_r == LAST_IDX) ? {IDX_W{1'b0}}
                                                           : grant_idx_r + 1'b1;
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                default: begin
                    ack         <= {REQUESTERS{1'b0}};
                    bus_addr    <= {ADDR_WIDTH{1'b0}};
                    bus_data_in <= {MGPIO_DATA_W{1'b0}};
                    bus_write   <= 1'b0;
                end
            endcase
        end
    end

endmodule
